enc_edit_ctrl: RTL and testbench

Edit/commit controller for the rotary-encoder setpoint path. Consumes single-cycle up/down step pulses from the quadrature decoder and a debounced push-button. Sequences a working value through per-digit editing (step 1/10/100/1000) and commits it to a registered setpoint on long press. Sits between the encoder decoder and the 4-digit display/consumer logic. Also arbitrates a host load port against the encoder.

---
 rtl/enc_pkg.sv | 6 +
 rtl/btn_press_timer.sv | 40 ++++
 rtl/enc_edit_ctrl.sv | 92 +++++++++
 tb/tb_enc_edit_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: shared types and constants for the encoder edit/commit controller.
package enc_pkg;
    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
    localparam int MAXV_DEF = 9999;
    localparam logic [13:0] STEP [4] = '{14'd1, 14'd10, 14'd100, 14'd1000};
endpackage

// File: rtl/btn_press_timer.sv
// btn_press_timer: classifies button presses as short (release before HOLD ticks) or long (HOLD ticks held).
module btn_press_timer #(
    parameter int HOLD = 1000
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick,
    input  logic btn,
    input  logic clr,
    output logic short_p,
    output logic long_p
);
    localparam int CW = $clog2(HOLD + 1);
    logic [CW-1:0] cnt;
    logic          btn_q;
    logic          blocked;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt     <= '0;
            btn_q   <= 1'b0;
            blocked <= 1'b0;
            short_p <= 1'b0;
            long_p  <= 1'b0;
        end else if (clr) begin
            // a press already under way is ignored until the button is let go
            cnt     <= '0;
            btn_q   <= btn;
            blocked <= btn;
            short_p <= 1'b0;
            long_p  <= 1'b0;
        end else begin
            btn_q   <= btn;
            blocked <= blocked & btn;
            short_p <= btn_q & ~btn & ~blocked & (cnt < CW'(HOLD));
            long_p  <= btn & tick & ~blocked & (cnt == CW'(HOLD - 1));
            cnt     <= !btn ? '0 : (tick && cnt < CW'(HOLD)) ? cnt + 1'b1 : cnt;
        end
    end
endmodule

// File: rtl/enc_edit_ctrl.sv
// enc_edit_ctrl: per-digit edit of a working value from encoder steps, committed to a setpoint on long press.
module enc_edit_ctrl
    import enc_pkg::*;
#(
    parameter int MAXV = MAXV_DEF,
    parameter bit WRAP = 1'b1,
    parameter int HOLD = 1000,
    parameter int TOUT = 8000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tick,
    input  logic        up,
    input  logic        dn,
    input  logic        btn,
    input  logic        ld,
    input  logic [13:0] ld_val,
    output logic [13:0] value,
    output logic [13:0] work,
    output logic        edit,
    output logic [1:0]  digit,
    output logic        commit
);
    localparam int TW = $clog2(TOUT + 1);
    state_t        state;
    logic [TW-1:0] tcnt;
    logic          short_p, long_p;
    logic [14:0]   w, s, sum;
    logic [13:0]   up_v, dn_v, ld_c;

    btn_press_timer #(.HOLD(HOLD)) u_btn (
        .clk(clk), .rstn(rstn), .tick(tick), .btn(btn), .clr(ld),
        .short_p(short_p), .long_p(long_p)
    );

    assign w    = {1'b0, work};
    assign s    = {1'b0, STEP[digit]};
    assign sum  = w + s;
    assign up_v = 14'((sum > 15'(MAXV)) ? (WRAP ? sum - 15'(MAXV + 1) : 15'(MAXV)) : sum);
    assign dn_v = 14'((w < s) ? (WRAP ? w + 15'(MAXV + 1) - s : 15'd0) : w - s);
    assign ld_c = (ld_val > 14'(MAXV)) ? 14'(MAXV) : ld_val;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            value  <= '0;
            work   <= '0;
            edit   <= 1'b0;
            digit  <= '0;
            commit <= 1'b0;
            tcnt   <= '0;
        end else if (ld) begin
            state  <= IDLE;
            value  <= ld_c;
            work   <= ld_c;
            edit   <= 1'b0;
            digit  <= '0;
            commit <= 1'b0;
            tcnt   <= '0;
        end else begin
            commit <= 1'b0;
            case (state)
                IDLE: if (short_p) begin
                    state <= EDIT;
                    edit  <= 1'b1;
                    digit <= '0;
                    tcnt  <= '0;
                end
                EDIT: if (long_p) begin
                    state  <= COMMIT;
                    value  <= work;
                    commit <= 1'b1;
                    edit   <= 1'b0;
                    digit  <= '0;
                end else begin
                    if (short_p) digit <= digit + 2'd1;
                    if (up ^ dn) work <= up ? up_v : dn_v;
                    // simultaneous up/dn leaves work alone but still counts as activity
                    if (up | dn | btn | short_p) tcnt <= '0;
                    else if (tick && tcnt == TW'(TOUT - 1)) begin
                        state <= IDLE;
                        edit  <= 1'b0;
                        digit <= '0;
                        work  <= value;
                        tcnt  <= '0;
                    end else if (tick) tcnt <= tcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enc_edit_ctrl.sv
// tb_enc_edit_ctrl: directed checks of edit/commit/timeout/load behaviour on wrapping and saturating instances.
module tb_enc_edit_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0, tick = 1'b0, up = 1'b0, dn = 1'b0, btn = 1'b0, ld = 1'b0;
    logic [13:0] ld_val = '0;
    logic [13:0] value_w, work_w, value_s, work_s;
    logic [1:0]  digit_w, digit_s;
    logic        edit_w, edit_s, commit_w, commit_s;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    enc_edit_ctrl #(.WRAP(1'b1)) u_w (
        .clk(clk), .rstn(rstn), .tick(tick), .up(up), .dn(dn), .btn(btn), .ld(ld), .ld_val(ld_val),
        .value(value_w), .work(work_w), .edit(edit_w), .digit(digit_w), .commit(commit_w)
    );
    enc_edit_ctrl #(.WRAP(1'b0)) u_s (
        .clk(clk), .rstn(rstn), .tick(tick), .up(up), .dn(dn), .btn(btn), .ld(ld), .ld_val(ld_val),
        .value(value_s), .work(work_s), .edit(edit_s), .digit(digit_s), .commit(commit_s)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic short_press();
        btn = 1'b1; cyc();
        btn = 1'b0; cyc(2);
    endtask

    task automatic pulse_up();
        up = 1'b1; cyc(); up = 1'b0;
    endtask

    task automatic load(input logic [13:0] v);
        ld = 1'b1; ld_val = v; cyc(); ld = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("rst_value", value_w, 0);
        chk("rst_work", work_w, 0);
        chk("rst_edit", edit_w, 0);
        chk("rst_digit", digit_w, 0);
        chk("rst_commit", commit_w, 0);
        rstn = 1'b1;
        cyc();

        // short press, 3 ups, long hold commits
        short_press();
        chk("enter_edit", edit_w, 1);
        chk("enter_digit", digit_w, 0);
        repeat (3) pulse_up();
        chk("edit_work3", work_w, 3);
        chk("edit_value0", value_w, 0);
        btn = 1'b1; tick = 1'b1;
        cyc(1000);
        chk("pre_commit_pulse", commit_w, 0);
        cyc();
        chk("commit_pulse", commit_w, 1);
        chk("commit_value", value_w, 3);
        chk("commit_edit", edit_w, 0);
        cyc();
        chk("commit_width", commit_w, 0);
        btn = 1'b0; tick = 1'b0;
        cyc(3);
        chk("long_release_edit", edit_w, 0);
        chk("long_release_digit", digit_w, 0);

        // upper bound wrap vs saturate
        load(14'd9998);
        chk("ld_9998", work_w, 9998);
        short_press();
        pulse_up();
        chk("wrap_up1", work_w, 9999);
        chk("sat_up1", work_s, 9999);
        pulse_up();
        chk("wrap_up2", work_w, 0);
        chk("sat_up2", work_s, 9999);
        pulse_up();
        chk("wrap_up3", work_w, 1);
        chk("sat_up3", work_s, 9999);

        // thousands digit, lower bound
        load(14'd500);
        chk("ld_edit_clr", edit_w, 0);
        short_press();
        repeat (3) short_press();
        chk("digit3", digit_w, 3);
        dn = 1'b1; cyc(); dn = 1'b0;
        chk("wrap_dn", work_w, 9500);
        chk("sat_dn", work_s, 0);

        // idle timeout cancels the edit
        load(14'd42);
        short_press();
        repeat (5) pulse_up();
        chk("to_work47", work_w, 47);
        tick = 1'b1;
        cyc(7999);
        chk("to_before", edit_w, 1);
        cyc();
        chk("to_edit", edit_w, 0);
        chk("to_work", work_w, 42);
        chk("to_value", value_w, 42);
        chk("to_commit", commit_w, 0);
        tick = 1'b0;

        // load while button held
        short_press();
        short_press();
        chk("ld_pre_digit", digit_w, 1);
        btn = 1'b1; cyc(2);
        load(14'd12000);
        chk("ld_clamp_value", value_w, 9999);
        chk("ld_clamp_work", work_w, 9999);
        chk("ld_held_edit", edit_w, 0);
        chk("ld_held_digit", digit_w, 0);
        btn = 1'b0; cyc(3);
        chk("ld_release_edit", edit_w, 0);
        chk("ld_release_digit", digit_w, 0);

        // up+dn together: no change, timeout restarted
        short_press();
        chk("ud_edit", edit_w, 1);
        tick = 1'b1;
        cyc(7000);
        up = 1'b1; dn = 1'b1; cyc(); up = 1'b0; dn = 1'b0;
        chk("ud_work", work_w, 9999);
        chk("ud_work_sat", work_s, 9999);
        cyc(7000);
        chk("ud_tout_cleared", edit_w, 1);
        cyc(999);
        chk("ud_tout_edge", edit_w, 1);
        cyc();
        chk("ud_tout_fire", edit_w, 0);
        tick = 1'b0;

        // reset mid-edit
        short_press();
        pulse_up();
        rstn = 1'b0; cyc();
        chk("rst_mid_edit", edit_w, 0);
        chk("rst_mid_work", work_w, 0);
        chk("rst_mid_value", value_w, 0);
        rstn = 1'b1; cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
